// File: rtl/parity_frame_if.sv
// Word-stream and frame-result signals of parity_frame.
// The source/consumer side uses master; the block itself uses slave.
interface parity_frame_if #(
    parameter int WIDTH     = 8,
    parameter int MAX_WORDS = 16
) ();
    localparam int CW = $clog2(MAX_WORDS + 1);

    logic [WIDTH-1:0] din0;
    logic             din_valid;
    logic             din_last;
    logic             din_ready;
    logic             chk_bit;
    logic             even_out;
    logic             odd_out;
    logic             frm_valid;
    logic             frm_ready;
    logic             frm_even;
    logic             frm_odd;
    logic             frm_err;
    logic [CW-1:0]    frm_count;
    logic             overflow;

    modport master (
        output din0, din_valid, din_last, chk_bit, frm_ready,
        input  din_ready, even_out, odd_out, frm_valid, frm_even,
               frm_odd, frm_err, frm_count, overflow
    );

    modport slave (
        input  din0, din_valid, din_last, chk_bit, frm_ready,
        output din_ready, even_out, odd_out, frm_valid, frm_even,
               frm_odd, frm_err, frm_count, overflow
    );
endinterface

// File: rtl/parity_frame.sv
// Streaming per-word parity plus frame-level parity accumulation and check.
// A frame closes on din_last or on reaching MAX_WORDS words, then holds its result.
module parity_frame #(
    parameter int WIDTH     = 8,
    parameter int MAX_WORDS = 16
) (
    input  logic           clk,
    input  logic           rst,
    parity_frame_if.slave  bus
);
    localparam int            CW      = $clog2(MAX_WORDS + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WORDS);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] word;
    logic             word_par;
    logic             accept;
    logic             close;
    logic             at_max;
    logic             acc;
    logic             acc_next;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_inc;

    logic             even_q;
    logic             odd_q;
    logic             frm_valid_q;
    logic             frm_even_q;
    logic             frm_err_q;
    logic [CW-1:0]    frm_count_q;
    logic             overflow_q;

    assign word     = bus.din0;
    assign word_par = ^word;

    assign bus.din_ready = (state != HOLD);
    assign accept        = bus.din_valid & bus.din_ready;

    // In IDLE the accumulator and count are treated as empty, so a new frame
    // never inherits anything from the previous one.
    always_comb begin
        acc_next = word_par;
        cnt_inc  = CW'(1);
        if (state == ACCUM) begin
            acc_next = acc ^ word_par;
            cnt_inc  = cnt + CW'(1);
        end
    end

    assign at_max = (cnt_inc == MAX_CNT);
    assign close  = accept & (bus.din_last | at_max);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = close ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (close) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (bus.frm_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Frame results stay latched after the handshake until the next frame closes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            even_q      <= 1'b0;
            odd_q       <= 1'b1;
            acc         <= 1'b0;
            cnt         <= '0;
            frm_valid_q <= 1'b0;
            frm_even_q  <= 1'b0;
            frm_err_q   <= 1'b0;
            frm_count_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            if (accept) begin
                even_q <= word_par;
                odd_q  <= ~word_par;
                acc    <= acc_next;
                cnt    <= cnt_inc;
            end
            if (close) begin
                frm_valid_q <= 1'b1;
                frm_even_q  <= acc_next;
                frm_err_q   <= bus.chk_bit ^ acc_next;
                frm_count_q <= cnt_inc;
                overflow_q  <= at_max & ~bus.din_last;
            end else if ((state == HOLD) && bus.frm_ready) begin
                frm_valid_q <= 1'b0;
                acc         <= 1'b0;
                cnt         <= '0;
            end
        end
    end

    assign bus.even_out  = even_q;
    assign bus.odd_out   = odd_q;
    assign bus.frm_valid = frm_valid_q;
    assign bus.frm_even  = frm_even_q;
    assign bus.frm_odd   = ~frm_even_q;
    assign bus.frm_err   = frm_err_q;
    assign bus.frm_count = frm_count_q;
    assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_parity_frame.sv
// Bench for parity_frame: a frame-level queue model checked every cycle,
// plus directed frames with hand-computed literal expectations.
module tb_parity_frame;
    localparam int WIDTH     = 8;
    localparam int MAX_WORDS = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    parity_frame_if #(.WIDTH(WIDTH), .MAX_WORDS(MAX_WORDS)) bus ();

    parity_frame #(.WIDTH(WIDTH), .MAX_WORDS(MAX_WORDS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: collect the words of the open frame, and on close derive parity from
    // the total count of one bits across the frame.
    logic [WIDTH-1:0] frame_q[$];
    bit               m_hold      = 1'b0;
    bit               m_even      = 1'b0;
    bit               m_frm_even  = 1'b0;
    bit               m_err       = 1'b0;
    bit               m_ovf       = 1'b0;
    int               m_count     = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_q.delete();
            m_hold     = 1'b0;
            m_even     = 1'b0;
            m_frm_even = 1'b0;
            m_err      = 1'b0;
            m_ovf      = 1'b0;
            m_count    = 0;
        end else if (m_hold) begin
            if (bus.frm_ready) m_hold = 1'b0;
        end else if (bus.din_valid) begin
            frame_q.push_back(bus.din0);
            m_even = ($countones(bus.din0) % 2) == 1;
            if (bus.din_last || frame_q.size() == MAX_WORDS) begin
                int ones;
                ones = 0;
                foreach (frame_q[i]) ones += $countones(frame_q[i]);
                m_frm_even = (ones % 2) == 1;
                m_count    = frame_q.size();
                m_err      = (bus.chk_bit != m_frm_even);
                m_ovf      = !bus.din_last;
                m_hold     = 1'b1;
                frame_q.delete();
            end
        end
    end

    always @(negedge clk) begin
        checkOutput("din_ready", 32'(bus.din_ready), 32'(!m_hold));
        checkOutput("even_out",  32'(bus.even_out),  32'(m_even));
        checkOutput("odd_out",   32'(bus.odd_out),   32'(!m_even));
        checkOutput("frm_valid", 32'(bus.frm_valid), 32'(m_hold));
        checkOutput("frm_even",  32'(bus.frm_even),  32'(m_frm_even));
        checkOutput("frm_odd",   32'(bus.frm_odd),   32'(!m_frm_even));
        checkOutput("frm_err",   32'(bus.frm_err),   32'(m_err));
        checkOutput("frm_count", 32'(bus.frm_count), 32'(m_count));
        checkOutput("overflow",  32'(bus.overflow),  32'(m_ovf));
    end

    task automatic applyStimulus(input logic [WIDTH-1:0] word, input logic last,
                                 input logic chk);
        int   waited;
        logic ok;
        waited = 0;
        @(negedge clk);
        bus.din0      = word;
        bus.din_valid = 1'b1;
        bus.din_last  = last;
        bus.chk_bit   = chk;
        ok = bus.din_ready;
        @(posedge clk);
        while (!ok && waited < 40) begin
            waited++;
            @(negedge clk);
            ok = bus.din_ready;
            @(posedge clk);
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: got no accept expected accept within 40 cycles");
        end
    endtask

    task automatic idle();
        @(negedge clk);
        bus.din_valid = 1'b0;
        bus.din_last  = 1'b0;
    endtask

    task automatic releaseResult();
        bus.frm_ready = 1'b1;
        @(negedge clk);
        bus.frm_ready = 1'b0;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_din_ready"}, 32'(bus.din_ready), 32'd1);
        checkOutput({tag, "_even_out"},  32'(bus.even_out),  32'd0);
        checkOutput({tag, "_odd_out"},   32'(bus.odd_out),   32'd1);
        checkOutput({tag, "_frm_valid"}, 32'(bus.frm_valid), 32'd0);
        checkOutput({tag, "_frm_even"},  32'(bus.frm_even),  32'd0);
        checkOutput({tag, "_frm_odd"},   32'(bus.frm_odd),   32'd1);
        checkOutput({tag, "_frm_err"},   32'(bus.frm_err),   32'd0);
        checkOutput({tag, "_frm_count"}, 32'(bus.frm_count), 32'd0);
        checkOutput({tag, "_overflow"},  32'(bus.overflow),  32'd0);
    endtask

    logic [WIDTH-1:0] single_words[4] = '{8'h00, 8'h01, 8'h03, 8'h80};
    logic             single_even[4]  = '{1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        bus.din0      = '0;
        bus.din_valid = 1'b0;
        bus.din_last  = 1'b0;
        bus.chk_bit   = 1'b0;
        bus.frm_ready = 1'b0;

        @(negedge clk);
        #2;
        checkResetValues("reset");
        rst = 1'b0;

        bus.frm_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(single_words[i], 1'b1, 1'b0);
            idle();
            checkOutput("single_even",  32'(bus.even_out),  32'(single_even[i]));
            checkOutput("single_odd",   32'(bus.odd_out),   32'(!single_even[i]));
            checkOutput("single_count", 32'(bus.frm_count), 32'd1);
            checkOutput("single_valid", 32'(bus.frm_valid), 32'd1);
        end
        @(negedge clk);
        bus.frm_ready = 1'b0;

        applyStimulus(8'hFF, 1'b0, 1'b0);
        applyStimulus(8'h01, 1'b0, 1'b0);
        applyStimulus(8'h10, 1'b1, 1'b0);
        idle();
        checkOutput("f3_valid", 32'(bus.frm_valid), 32'd1);
        checkOutput("f3_even",  32'(bus.frm_even),  32'd0);
        checkOutput("f3_count", 32'(bus.frm_count), 32'd3);
        checkOutput("f3_err",   32'(bus.frm_err),   32'd0);
        releaseResult();

        applyStimulus(8'hFF, 1'b0, 1'b1);
        applyStimulus(8'h01, 1'b0, 1'b1);
        applyStimulus(8'h10, 1'b1, 1'b1);
        idle();
        checkOutput("f3b_err", 32'(bus.frm_err), 32'd1);
        bus.din0      = 8'h07;
        bus.din_valid = 1'b1;
        bus.din_last  = 1'b1;
        bus.chk_bit   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("stall_ready", 32'(bus.din_ready), 32'd0);
            checkOutput("stall_valid", 32'(bus.frm_valid), 32'd1);
            checkOutput("stall_count", 32'(bus.frm_count), 32'd3);
            checkOutput("stall_err",   32'(bus.frm_err),   32'd1);
        end
        releaseResult();
        checkOutput("release_ready", 32'(bus.din_ready), 32'd1);
        checkOutput("release_valid", 32'(bus.frm_valid), 32'd0);
        idle();
        checkOutput("pending_valid", 32'(bus.frm_valid), 32'd1);
        checkOutput("pending_even",  32'(bus.frm_even),  32'd1);
        checkOutput("pending_count", 32'(bus.frm_count), 32'd1);
        releaseResult();

        for (int i = 0; i < MAX_WORDS; i++) applyStimulus(8'h01, 1'b0, 1'b0);
        idle();
        checkOutput("ovf_valid", 32'(bus.frm_valid), 32'd1);
        checkOutput("ovf_flag",  32'(bus.overflow),  32'd1);
        checkOutput("ovf_even",  32'(bus.frm_even),  32'd0);
        checkOutput("ovf_count", 32'(bus.frm_count), 32'd16);
        releaseResult();
        applyStimulus(8'h01, 1'b0, 1'b0);
        applyStimulus(8'h01, 1'b0, 1'b0);
        applyStimulus(8'h80, 1'b1, 1'b1);
        idle();
        checkOutput("rest_count", 32'(bus.frm_count), 32'd3);
        checkOutput("rest_even",  32'(bus.frm_even),  32'd1);
        checkOutput("rest_ovf",   32'(bus.overflow),  32'd0);
        checkOutput("rest_err",   32'(bus.frm_err),   32'd0);
        releaseResult();

        for (int i = 0; i < MAX_WORDS; i++)
            applyStimulus(8'h01, (i == MAX_WORDS - 1), 1'b1);
        idle();
        checkOutput("full_ovf",   32'(bus.overflow),  32'd0);
        checkOutput("full_count", 32'(bus.frm_count), 32'd16);
        checkOutput("full_err",   32'(bus.frm_err),   32'd1);
        releaseResult();

        applyStimulus(8'hA5, 1'b0, 1'b0);
        applyStimulus(8'h3C, 1'b0, 1'b0);
        idle();
        checkOutput("pre_rst_ready", 32'(bus.din_ready), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkResetValues("midrst");
        @(negedge clk);
        #2;
        rst = 1'b0;
        applyStimulus(8'h07, 1'b1, 1'b0);
        idle();
        checkOutput("after_rst_even",  32'(bus.frm_even),  32'd1);
        checkOutput("after_rst_count", 32'(bus.frm_count), 32'd1);
        checkOutput("after_rst_err",   32'(bus.frm_err),   32'd1);
        releaseResult();
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
